// File: rtl/proc_run_ctrl_pkg.sv
// proc_run_pkg: shared widths, FSM encoding and a saturating counter helper for proc_run_ctrl
// Contents: PC_W (processor address/data width), CNT_W (run cycle counter width),
//           state_e (run controller states), sat_inc (increment that sticks at all-ones)
package proc_run_pkg;
  localparam int PC_W = 64;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + CNT_W'(1);
  endfunction
endpackage

// File: rtl/proc_run_ctrl_if.sv
// proc_run_ctrl_if: run-control, processor-side and trace-read signals of proc_run_ctrl
// Modports: slave  - the controller (takes start/PCs/processor state, drives status and trace data)
//           master - the host/processor side driving the controller
interface proc_run_ctrl_if;
  import proc_run_pkg::*;
  logic              start;
  logic [PC_W-1:0]   startpc_in;
  logic [PC_W-1:0]   finalpc_in;
  logic [PC_W-1:0]   currentpc;
  logic [PC_W-1:0]   memtoregout;
  logic              proc_resetl;
  logic [PC_W-1:0]   proc_startpc;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;
  logic [PC_W-1:0]   last_result;
  logic              trace_rd_en;
  logic [PC_W-1:0]   trace_rd_data;
  logic              trace_empty;
  logic              trace_full;
  modport slave (
    input  start, startpc_in, finalpc_in, currentpc, memtoregout, trace_rd_en,
    output proc_resetl, proc_startpc, busy, done, timeout, cycle_count, last_result,
           trace_rd_data, trace_empty, trace_full
  );
  modport master (
    output start, startpc_in, finalpc_in, currentpc, memtoregout, trace_rd_en,
    input  proc_resetl, proc_startpc, busy, done, timeout, cycle_count, last_result,
           trace_rd_data, trace_empty, trace_full
  );
endinterface

// File: rtl/proc_run_ctrl_trace_fifo.sv
// run_trace_fifo: PC trace FIFO with flush, registered read data, drop-on-full pushes
// Ports: clk, rst (sync, active high), flush_i (empty the FIFO), push_i/din_i (write),
//        pop_i (read, ignored when empty), dout_o (registered, valid the cycle after pop_i),
//        empty_o, full_o
module run_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic do_push, do_pop;
  assign empty_o = wp_q == rp_q;
  assign full_o = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop = pop_i && !empty_o;
  // a pop in the same cycle frees the slot, so a push while full still lands
  assign do_push = push_i && (!full_o || do_pop);
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + (AW+1)'(1);
      if (do_pop) rp_q <= rp_q + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q[AW-1:0]] <= din_i;
  end
  always_ff @(posedge clk) begin
    if (rst) dout_o <= '0;
    else if (do_pop) dout_o <= mem_q[rp_q[AW-1:0]];
  end
endmodule

// File: rtl/proc_run_ctrl.sv
// proc_run_ctrl: holds a processor in reset, runs it until it reaches a final PC or a watchdog limit
// Ports: CLK (rising edge), reset (sync, active high), bus (proc_run_ctrl_if.slave: start/PCs in,
//        proc_resetl/proc_startpc to the processor, busy/done/timeout/cycle_count/last_result status,
//        trace_rd_en/trace_rd_data/trace_empty/trace_full PC trace read port)
// Build option: RUN_CTRL_TRACE_EN builds the PC trace FIFO; otherwise the trace port reads as empty.
module proc_run_ctrl
  import proc_run_pkg::*;
#(
  parameter int RESET_CYCLES = 2,
  parameter int WDOG_LIMIT = 255,
  parameter int TRACE_DEPTH = 16
) (
  input logic CLK,
  input logic reset,
  proc_run_ctrl_if.slave bus
);
  localparam logic [15:0] HOLD_LAST = 16'(RESET_CYCLES - 1);
  state_e state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [PC_W-1:0] spc_q, spc_d, fpc_q, fpc_d, res_q, res_d;
  logic done_q, done_d, to_q, to_d;
  logic accept, fin, wdog;
  assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_TIMEOUT);
  assign fin = bus.currentpc >= fpc_q;
  assign cnt_inc = sat_inc(cnt_q);
  // the watchdog compares the count including the current run cycle
  assign wdog = cnt_inc == CNT_W'(WDOG_LIMIT);
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    cnt_d = cnt_q;
    spc_d = spc_q;
    fpc_d = fpc_q;
    res_d = res_q;
    done_d = done_q;
    to_d = to_q;
    if (accept) begin
      state_d = S_HOLD;
      hold_d = '0;
      cnt_d = '0;
      spc_d = bus.startpc_in;
      fpc_d = bus.finalpc_in;
      done_d = 1'b0;
      to_d = 1'b0;
    end else if (state_q == S_HOLD) begin
      hold_d = hold_q + 16'd1;
      state_d = hold_q >= HOLD_LAST ? S_RUN : S_HOLD;
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_inc;
      if (fin) begin
        state_d = S_DONE;
        done_d = 1'b1;
        res_d = bus.memtoregout;
      end else if (wdog) begin
        state_d = S_TIMEOUT;
        to_d = 1'b1;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q <= '0;
      cnt_q <= '0;
      spc_q <= '0;
      fpc_q <= '0;
      res_q <= '0;
      done_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      cnt_q <= cnt_d;
      spc_q <= spc_d;
      fpc_q <= fpc_d;
      res_q <= res_d;
      done_q <= done_d;
      to_q <= to_d;
    end
  end
  assign bus.proc_resetl = state_q == S_RUN;
  assign bus.proc_startpc = spc_q;
  assign bus.busy = state_q == S_HOLD || state_q == S_RUN;
  assign bus.done = done_q;
  assign bus.timeout = to_q;
  assign bus.cycle_count = cnt_q;
  assign bus.last_result = res_q;
`ifdef RUN_CTRL_TRACE_EN
  run_trace_fifo #(.DEPTH(TRACE_DEPTH), .W(PC_W)) u_trace (
    .clk(CLK),
    .rst(reset),
    .flush_i(accept),
    .push_i(state_q == S_RUN),
    .din_i(bus.currentpc),
    .pop_i(bus.trace_rd_en),
    .dout_o(bus.trace_rd_data),
    .empty_o(bus.trace_empty),
    .full_o(bus.trace_full)
  );
`else
  logic unused_trace;
  assign unused_trace = bus.trace_rd_en ^ (TRACE_DEPTH == 0);
  assign bus.trace_rd_data = '0;
  assign bus.trace_empty = 1'b1;
  assign bus.trace_full = 1'b0;
`endif
endmodule

// File: tb/tb_proc_run_ctrl.sv
// tb_proc_run_ctrl: directed self-checking bench for proc_run_ctrl with a stepping-PC processor stub
module tb_proc_run_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int holds, n;
  proc_run_ctrl_if bus ();
  proc_run_ctrl #(.RESET_CYCLES(2), .WDOG_LIMIT(255), .TRACE_DEPTH(16)) dut (
    .CLK(clk),
    .reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end
  function automatic logic [63:0] pc_of(input int mode, input int k);
    logic [63:0] kk;
    kk = 64'(k);
    case (mode)
      0: return kk * 64'd4;
      1: return 64'h8;
      2: return k == 254 ? 64'h14 : 64'h8;
      default: return 64'h40 + kk * 64'd4;
    endcase
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic run(input logic [63:0] spc, input logic [63:0] fpc, input int mode);
    holds = 0;
    n = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.startpc_in = spc;
    bus.finalpc_in = fpc;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 400 && bus.busy; i++) begin
      if (!bus.proc_resetl) begin
        holds++;
        checks++;
        if (bus.proc_startpc !== spc) begin failures++; $display("FAIL hold_startpc: got %0h expected %0h", bus.proc_startpc, spc); end
      end else begin
        bus.currentpc = pc_of(mode, n);
        bus.memtoregout = bus.currentpc >= fpc ? 64'hDEAD : 64'h1111;
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL run_bound: busy got %b expected 0 within 400 cycles", bus.busy); end
  endtask
  task automatic test_reset();
    do_reset();
    checks += 10;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    if (bus.timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout: got %b expected 0", bus.timeout); end
    if (bus.proc_resetl !== 1'b0) begin failures++; $display("FAIL rst_resetl: got %b expected 0", bus.proc_resetl); end
    if (bus.proc_startpc !== 64'h0) begin failures++; $display("FAIL rst_startpc: got %0h expected 0", bus.proc_startpc); end
    if (bus.cycle_count !== 16'h0) begin failures++; $display("FAIL rst_count: got %0h expected 0", bus.cycle_count); end
    if (bus.last_result !== 64'h0) begin failures++; $display("FAIL rst_result: got %0h expected 0", bus.last_result); end
    if (bus.trace_empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %b expected 1", bus.trace_empty); end
    if (bus.trace_full !== 1'b0) begin failures++; $display("FAIL rst_full: got %b expected 0", bus.trace_full); end
    if (bus.trace_rd_data !== 64'h0) begin failures++; $display("FAIL rst_rdata: got %0h expected 0", bus.trace_rd_data); end
  endtask
  task automatic test_basic();
    run(64'h0, 64'h14, 0);
    checks += 8;
    if (holds !== 2) begin failures++; $display("FAIL basic_holds: got %0d expected 2", holds); end
    if (n !== 6) begin failures++; $display("FAIL basic_run_cycles: got %0d expected 6", n); end
    if (bus.done !== 1'b1) begin failures++; $display("FAIL basic_done: got %b expected 1", bus.done); end
    if (bus.timeout !== 1'b0) begin failures++; $display("FAIL basic_timeout: got %b expected 0", bus.timeout); end
    if (bus.cycle_count !== 16'd6) begin failures++; $display("FAIL basic_count: got %0d expected 6", bus.cycle_count); end
    if (bus.proc_resetl !== 1'b0) begin failures++; $display("FAIL basic_resetl: got %b expected 0", bus.proc_resetl); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy: got %b expected 0", bus.busy); end
    if (bus.last_result !== 64'hDEAD) begin failures++; $display("FAIL basic_result: got %0h expected dead", bus.last_result); end
  endtask
  task automatic test_last_result();
    bus.memtoregout = 64'h5555;
    bus.currentpc = 64'h100;
    repeat (5) @(negedge clk);
    checks += 3;
    if (bus.last_result !== 64'hDEAD) begin failures++; $display("FAIL held_result: got %0h expected dead", bus.last_result); end
    if (bus.done !== 1'b1) begin failures++; $display("FAIL held_done: got %b expected 1", bus.done); end
    if (bus.cycle_count !== 16'd6) begin failures++; $display("FAIL held_count: got %0d expected 6", bus.cycle_count); end
  endtask
  task automatic test_equal_pc();
    run(64'h40, 64'h40, 3);
    checks += 4;
    if (n !== 1) begin failures++; $display("FAIL eq_run_cycles: got %0d expected 1", n); end
    if (bus.done !== 1'b1) begin failures++; $display("FAIL eq_done: got %b expected 1", bus.done); end
    if (bus.cycle_count !== 16'd1) begin failures++; $display("FAIL eq_count: got %0d expected 1", bus.cycle_count); end
    if (bus.proc_startpc !== 64'h40) begin failures++; $display("FAIL eq_startpc: got %0h expected 40", bus.proc_startpc); end
  endtask
  task automatic test_timeout();
    run(64'h0, 64'h14, 1);
    checks += 5;
    if (bus.timeout !== 1'b1) begin failures++; $display("FAIL wdog_timeout: got %b expected 1", bus.timeout); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL wdog_done: got %b expected 0", bus.done); end
    if (bus.cycle_count !== 16'd255) begin failures++; $display("FAIL wdog_count: got %0d expected 255", bus.cycle_count); end
    if (bus.proc_resetl !== 1'b0) begin failures++; $display("FAIL wdog_resetl: got %b expected 0", bus.proc_resetl); end
    if (n !== 255) begin failures++; $display("FAIL wdog_run_cycles: got %0d expected 255", n); end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.timeout !== 1'b1) begin failures++; $display("FAIL wdog_sticky: got %b expected 1", bus.timeout); end
  endtask
  task automatic test_boundary();
    run(64'h0, 64'h14, 2);
    checks += 3;
    if (bus.done !== 1'b1) begin failures++; $display("FAIL edge_done: got %b expected 1", bus.done); end
    if (bus.timeout !== 1'b0) begin failures++; $display("FAIL edge_timeout: got %b expected 0", bus.timeout); end
    if (bus.cycle_count !== 16'd255) begin failures++; $display("FAIL edge_count: got %0d expected 255", bus.cycle_count); end
  endtask
  task automatic test_mid_run();
    bus.currentpc = 64'h8;
    @(negedge clk);
    bus.start = 1'b1;
    bus.startpc_in = 64'h20;
    bus.finalpc_in = 64'h1000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.startpc_in = 64'h999;
    @(negedge clk);
    bus.start = 1'b0;
    checks += 4;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL ign_busy: got %b expected 1", bus.busy); end
    if (bus.proc_resetl !== 1'b1) begin failures++; $display("FAIL ign_resetl: got %b expected 1", bus.proc_resetl); end
    if (bus.proc_startpc !== 64'h20) begin failures++; $display("FAIL ign_startpc: got %0h expected 20", bus.proc_startpc); end
    if (bus.cycle_count !== 16'd4) begin failures++; $display("FAIL ign_count: got %0d expected 4", bus.cycle_count); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 7;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    if (bus.timeout !== 1'b0) begin failures++; $display("FAIL abort_timeout: got %b expected 0", bus.timeout); end
    if (bus.proc_resetl !== 1'b0) begin failures++; $display("FAIL abort_resetl: got %b expected 0", bus.proc_resetl); end
    if (bus.proc_startpc !== 64'h0) begin failures++; $display("FAIL abort_startpc: got %0h expected 0", bus.proc_startpc); end
    if (bus.cycle_count !== 16'd0) begin failures++; $display("FAIL abort_count: got %0d expected 0", bus.cycle_count); end
    if (bus.last_result !== 64'h0) begin failures++; $display("FAIL abort_result: got %0h expected 0", bus.last_result); end
  endtask
  task automatic test_trace();
`ifdef RUN_CTRL_TRACE_EN
    run(64'h0, 64'h4C, 0);
    checks += 3;
    if (n !== 20) begin failures++; $display("FAIL tr_run_cycles: got %0d expected 20", n); end
    if (bus.trace_full !== 1'b1) begin failures++; $display("FAIL tr_full: got %b expected 1", bus.trace_full); end
    if (bus.trace_empty !== 1'b0) begin failures++; $display("FAIL tr_not_empty: got %b expected 0", bus.trace_empty); end
    bus.trace_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (bus.trace_rd_data !== 64'(i * 4)) begin failures++; $display("FAIL tr_data[%0d]: got %0h expected %0h", i, bus.trace_rd_data, i * 4); end
    end
    bus.trace_rd_en = 1'b0;
    checks++;
    if (bus.trace_empty !== 1'b1) begin failures++; $display("FAIL tr_empty: got %b expected 1", bus.trace_empty); end
    bus.trace_rd_en = 1'b1;
    @(negedge clk);
    bus.trace_rd_en = 1'b0;
    checks++;
    if (bus.trace_rd_data !== 64'h3C) begin failures++; $display("FAIL tr_empty_read: got %0h expected 3c", bus.trace_rd_data); end
`else
    run(64'h0, 64'h4C, 0);
    bus.trace_rd_en = 1'b1;
    @(negedge clk);
    bus.trace_rd_en = 1'b0;
    checks += 4;
    if (n !== 20) begin failures++; $display("FAIL tr_run_cycles: got %0d expected 20", n); end
    if (bus.trace_empty !== 1'b1) begin failures++; $display("FAIL tr_off_empty: got %b expected 1", bus.trace_empty); end
    if (bus.trace_full !== 1'b0) begin failures++; $display("FAIL tr_off_full: got %b expected 0", bus.trace_full); end
    if (bus.trace_rd_data !== 64'h0) begin failures++; $display("FAIL tr_off_data: got %0h expected 0", bus.trace_rd_data); end
`endif
  endtask
  initial begin
    bus.start = 1'b0;
    bus.startpc_in = '0;
    bus.finalpc_in = '0;
    bus.currentpc = '0;
    bus.memtoregout = '0;
    bus.trace_rd_en = 1'b0;
    test_reset();
    test_basic();
    test_last_result();
    test_equal_pc();
    test_timeout();
    test_boundary();
    test_mid_run();
    test_trace();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/proc_run_ctrl.md
PROC_RUN_CTRL -- requirements
Module: proc_run_ctrl

Interface
REQ-001 Parameter RESET_CYCLES, default 2, SHALL set the number of cycles proc_resetl is held low before a run.
REQ-002 Parameter WDOG_LIMIT, default 255, SHALL set the run-cycle count at which a run times out.
REQ-003 Parameter TRACE_DEPTH, default 16, SHALL set the PC trace FIFO entry count (power of two).
REQ-004 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle pulse that launches a run.
REQ-007 startpc_in  in  64  program start address, latched on accepted start.
REQ-008 finalpc_in  in  64  program end address, latched on accepted start.
REQ-009 currentpc  in  64  processor current PC.
REQ-010 memtoregout  in  64  processor write-back value.
REQ-011 proc_resetl  out  1  active-low processor reset.
REQ-012 proc_startpc  out  64  processor start PC.
REQ-013 busy / done / timeout  out  1 each  run status.
REQ-014 cycle_count  out  16  run cycles elapsed.
REQ-015 last_result  out  64  memtoregout captured on the final run cycle.
REQ-016 trace_rd_en  in  1; trace_rd_data  out  64; trace_empty, trace_full  out  1 each.

Function
REQ-017 FSM states SHALL be IDLE, HOLD, RUN, DONE and TIMEOUT.
REQ-018 start in IDLE, DONE or TIMEOUT SHALL latch both PCs, clear cycle_count/done/timeout, flush the trace and enter HOLD next cycle; start in HOLD or RUN SHALL be ignored.
REQ-019 HOLD SHALL drive proc_resetl=0 and proc_startpc=latched startpc for exactly RESET_CYCLES cycles, then enter RUN.
REQ-020 RUN SHALL drive proc_resetl=1 and increment cycle_count by one per cycle, saturating at 16'hFFFF.
REQ-021 In RUN, currentpc >= latched finalpc (unsigned 64-bit) SHALL enter DONE next cycle and capture memtoregout into last_result.
REQ-022 In RUN, cycle_count == WDOG_LIMIT with the finish condition false SHALL enter TIMEOUT next cycle.
REQ-023 Finish and timeout in the same cycle SHALL resolve to DONE.
REQ-024 DONE and TIMEOUT SHALL drive proc_resetl=0 (processor frozen); done and timeout SHALL be sticky until the next accepted start or reset.
REQ-025 busy SHALL be 1 exactly in HOLD and RUN.
REQ-026 startpc_in == finalpc_in SHALL still run one RUN cycle, then enter DONE.

Reset
REQ-027 reset SHALL force IDLE, proc_resetl=0, proc_startpc=0, busy=0, done=0, timeout=0, cycle_count=0, last_result=0, trace empty, trace_rd_data=0.
REQ-028 reset asserted during HOLD or RUN SHALL abort the run with no done or timeout indication.

Configuration
REQ-029 With RUN_CTRL_TRACE_EN defined, every RUN cycle SHALL push currentpc into the trace FIFO.
REQ-030 Pushes while full SHALL be dropped; trace_rd_en while empty SHALL be ignored.
REQ-031 Push and pop while full SHALL both occur.
REQ-032 trace_rd_data SHALL be registered and valid the cycle after trace_rd_en.
REQ-033 Without RUN_CTRL_TRACE_EN, the trace ports SHALL remain present, with trace_empty=1, trace_full=0 and trace_rd_data=0, and no FIFO storage SHALL be built.

Structure
REQ-034 Package proc_run_pkg SHALL hold the PC width constant (64), the state typedef and the encodings.
REQ-035 The FIFO SHALL be a sub-module, run_trace_fifo.

Verification
REQ-036 Start with startpc=0x0, finalpc=0x14 and a stub PC stepping +4 per RUN cycle -> 2 HOLD cycles, done=1 after currentpc=0x14, cycle_count=6.
REQ-037 finalpc=0x14 with the stub PC stuck at 0x8 -> timeout=1 when cycle_count=255, proc_resetl=0, done=0.
REQ-038 finalpc reached on exactly the cycle where cycle_count=255 -> done=1, timeout=0.
REQ-039 start pulsed mid-RUN -> ignored; reset pulsed mid-RUN -> IDLE with all outputs at reset values.
REQ-040 TRACE_EN on, run of 20 cycles with depth 16 -> trace_full=1; reads return 0x0, 0x4, ... 0x3C; trace_empty=1 after 16 reads.
REQ-041 memtoregout=0xDEAD on the finishing cycle -> last_result=0xDEAD, held until the next start.
